// File: rtl/dmem_if.sv
// dmem_if: load/store request and response bundle between the pipelined core
// and its data-memory responder.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The sender raises valid with stable payload and keeps both
// unchanged until that edge; ready may be raised or lowered at any time and
// never depends combinationally on valid.
//
// Signals (widths fixed at 32-bit data/address):
//   req_valid/req_ready        request handshake (core -> responder)
//   req_we/req_addr/req_wdata  request payload (store flag, word index, data)
//   rsp_valid/rsp_ready        response handshake (responder -> core)
//   rsp_rdata/rsp_err          response payload (load data, error flags)
// Modports: master = core side, slave = responder side.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory slave with WAIT wait states per
// access, one outstanding request, out-of-range reporting and optional parity.
//
// Optional feature macro: DMEM_PARITY_EN. When defined, a parity bit is kept
// per word and checked on loads (rsp_err[1]); when undefined, rsp_err[1] is 0.
//
// Parameters: DEPTH (words, power of two >= 2), AW = log2(DEPTH),
//             WAIT (0..15 wait states).
// Ports:
//   clk1       sole clock, rising edge
//   rst        asynchronous active-high reset
//   bus        dmem_if.slave request/response bundle
//   dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 RESP)
//
// All outputs are flops or state decodes; no input reaches an output
// combinationally. Memory and parity contents are never reset.
module dmem_responder #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int WAIT  = 2
) (
    input  logic       clk1,
    input  logic       rst,
    dmem_if.slave      bus,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        we_q,    we_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  err_q,   err_d;

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] idx;
    logic        out_of_range;
    logic        mem_we;
    logic        par_err;

    assign idx          = addr_q[AW-1:0];
    // Any set bit above the index field means the word is beyond DEPTH.
    assign out_of_range = |addr_q[31:AW];

`ifdef DMEM_PARITY_EN
    logic par [DEPTH];
    assign par_err = (^mem[idx]) ^ par[idx];
`else
    assign par_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = WAIT_CNT;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access edge: result is registered so it appears with RESP.
                    state_d = ST_RESP;
                    if (out_of_range) begin
                        rdata_d = 32'd0;
                        err_d   = 2'b01;
                    end else if (we_q) begin
                        mem_we  = 1'b1;
                        rdata_d = 32'd0;
                        err_d   = 2'b00;
                    end else begin
                        rdata_d = mem[idx];
                        err_d   = {par_err, 1'b0};
                    end
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 2'b00;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                rdata_d = 32'd0;
                err_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage has no reset. mem_we is decoded from state_q, which reset holds
    // in IDLE, so a store aborted by reset never reaches the array.
    always_ff @(posedge clk1) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
`ifdef DMEM_PARITY_EN
            par[idx] <= ^wdata_q;
`endif
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int TB_WAIT = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic clk1;
  logic rst;
  logic [1:0] dbg0, dbg1;

  dmem_if bus0 ();
  dmem_if bus1 ();

  dmem_responder #(.DEPTH(1024), .AW(10), .WAIT(TB_WAIT)) dut (
    .clk1(clk1), .rst(rst), .bus(bus0.slave), .dbg_state(dbg0)
  );

  dmem_responder #(.DEPTH(1024), .AW(10), .WAIT(0)) dut_w0 (
    .clk1(clk1), .rst(rst), .bus(bus1.slave), .dbg_state(dbg1)
  );

  // ---------------- clock / reset ----------------
  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [33:0] exp_q[$];   // {err, rdata} for the WAIT=2 instance
  logic [33:0] exp1_q[$];  // {err, rdata} for the WAIT=0 instance
  int acc1_q[$];           // accept cycle numbers for the WAIT=0 instance

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[9];

  // ---------------- driver (WAIT=2 instance) ----------------
  // Runs one full transaction; hold = cycles rsp_ready is kept low once the
  // response is visible, with stray req_valid pulses during that time.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                        input int hold);
    int lat;
    int guard;
    logic [33:0] e;
    guard = 0;
    while (bus0.req_ready !== 1'b1 && guard < 50) begin
      @(posedge clk1); #1;
      guard++;
    end
    bus0.req_valid = 1'b1;
    bus0.req_we    = we;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
    @(posedge clk1); #1;
    bus0.req_valid = 1'b0;
    bus0.req_wdata = $urandom;
    exp_q.push_back({exp_err, exp_rdata});
    lat = 0;
    while (bus0.rsp_valid !== 1'b1 && lat < 40) begin
      check("busy_req_ready", 64'(bus0.req_ready), 64'd0);
      @(posedge clk1); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(TB_WAIT + 1));
    if (bus0.rsp_valid !== 1'b1) begin
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    check("rsp_data", {30'd0, bus0.rsp_err, bus0.rsp_rdata}, {30'd0, e});
    for (int h = 0; h < hold; h++) begin
      bus0.req_valid = h[0];
      bus0.req_we    = 1'b1;
      bus0.req_addr  = 32'd5;
      bus0.req_wdata = 32'hBAD0_0000 | h;
      @(posedge clk1); #1;
      check("stall_valid", 64'(bus0.rsp_valid), 64'd1);
      check("stall_ready", 64'(bus0.req_ready), 64'd0);
      check("stall_data", {30'd0, bus0.rsp_err, bus0.rsp_rdata}, {30'd0, e});
    end
    bus0.req_valid = 1'b0;
    bus0.rsp_ready = 1'b1;
    @(posedge clk1); #1;
    bus0.rsp_ready = 1'b0;
    check("post_rsp_valid", 64'(bus0.rsp_valid), 64'd0);
    check("post_req_ready", 64'(bus0.req_ready), 64'd1);
    check("post_rsp_clear", {30'd0, bus0.rsp_err, bus0.rsp_rdata}, 64'd0);
  endtask

  // ---------------- monitor (WAIT=0 instance) ----------------
  always @(negedge clk1) begin
    if (bus1.rsp_valid === 1'b1) begin
      if (exp1_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL w0_unexpected: got response %h with nothing pending", bus1.rsp_rdata);
      end else begin
        logic [33:0] e;
        int a;
        e = exp1_q.pop_front();
        a = acc1_q.pop_front();
        check("w0_rsp_data", {30'd0, bus1.rsp_err, bus1.rsp_rdata}, {30'd0, e});
        check("w0_latency", 64'(cyc - a), 64'd1);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rnd_data [4];
    logic [31:0] w0_data [4];
    int prev_acc;
    int guard;

    vecs[0] = '{1'b1, 32'd5,          32'hDEAD_BEEF, 32'h0,         2'b00};
    vecs[1] = '{1'b0, 32'd5,          32'h0,         32'hDEAD_BEEF, 2'b00};
    vecs[2] = '{1'b1, 32'd3,          32'h0BAD_F00D, 32'h0,         2'b00};
    vecs[3] = '{1'b0, 32'd1024,       32'h0,         32'h0,         2'b01};
    vecs[4] = '{1'b1, 32'h8000_0003,  32'hFFFF_FFFF, 32'h0,         2'b01};
    vecs[5] = '{1'b0, 32'd3,          32'h0,         32'h0BAD_F00D, 2'b00};
    vecs[6] = '{1'b1, 32'd7,          32'hAAAA_5555, 32'h0,         2'b00};
    vecs[7] = '{1'b1, 32'd1023,       32'h1357_9BDF, 32'h0,         2'b00};
    vecs[8] = '{1'b0, 32'd1023,       32'h0,         32'h1357_9BDF, 2'b00};

    rst = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus0.rsp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    bus1.rsp_ready = 1'b1;
    repeat (3) @(posedge clk1);
    #1 rst = 1'b0;
    @(posedge clk1); #1;

    check("reset_req_ready", 64'(bus0.req_ready), 64'd1);
    check("reset_rsp_valid", 64'(bus0.rsp_valid), 64'd0);
    check("reset_rsp", {30'd0, bus0.rsp_err, bus0.rsp_rdata}, 64'd0);
    check("reset_state", 64'(dbg0), 64'(ST_IDLE));

    // Table-driven vectors.
    for (int i = 0; i < 9; i++)
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, 0);

    // Random data stores then loads at spread addresses.
    for (int i = 0; i < 4; i++) begin
      rnd_data[i] = $urandom;
      do_txn(1'b1, 32'(100 + i * 37), rnd_data[i], 32'h0, 2'b00, 0);
    end
    for (int i = 0; i < 4; i++)
      do_txn(1'b0, 32'(100 + i * 37), 32'h0, rnd_data[i], 2'b00, 0);

    // Response stall: rsp_ready low for 5 cycles, stray request pulses ignored.
    do_txn(1'b0, 32'd5, 32'h0, 32'hDEAD_BEEF, 2'b00, 5);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk1); #1;
      check("stall_no_accept", 64'(dbg0), 64'(ST_IDLE));
    end
    do_txn(1'b0, 32'd5, 32'h0, 32'hDEAD_BEEF, 2'b00, 0);

    // Reset one cycle after accepting a store to word 7 aborts it.
    bus0.req_valid = 1'b1;
    bus0.req_we    = 1'b1;
    bus0.req_addr  = 32'd7;
    bus0.req_wdata = 32'h1234_5678;
    @(posedge clk1); #1;
    bus0.req_valid = 1'b0;
    check("abort_accepted", 64'(bus0.req_ready), 64'd0);
    @(posedge clk1); #1;
    rst = 1'b1;
    #1;
    check("abort_state", 64'(dbg0), 64'(ST_IDLE));
    check("abort_rsp_valid", 64'(bus0.rsp_valid), 64'd0);
    check("abort_rsp", {30'd0, bus0.rsp_err, bus0.rsp_rdata}, 64'd0);
    repeat (2) @(posedge clk1);
    #1 rst = 1'b0;
    @(posedge clk1); #1;
    check("abort_req_ready", 64'(bus0.req_ready), 64'd1);
    do_txn(1'b0, 32'd7, 32'h0, 32'hAAAA_5555, 2'b00, 0);
    do_txn(1'b0, 32'd5, 32'h0, 32'hDEAD_BEEF, 2'b00, 0);

`ifdef DMEM_PARITY_EN
    do_txn(1'b1, 32'd9, 32'h0000_0001, 32'h0, 2'b00, 0);
    dut.par[9] = ~dut.par[9];
    do_txn(1'b0, 32'd9, 32'h0, 32'h0000_0001, 2'b10, 0);
`endif

    // WAIT=0 instance: continuous requests with rsp_ready tied high.
    prev_acc = 0;
    bus1.req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int a;
      if (i < 4) begin
        w0_data[i] = $urandom;
        bus1.req_we    = 1'b1;
        bus1.req_addr  = 32'(10 + i);
        bus1.req_wdata = w0_data[i];
      end else begin
        bus1.req_we    = 1'b0;
        bus1.req_addr  = 32'(10 + i - 4);
        bus1.req_wdata = $urandom;
      end
      guard = 0;
      @(negedge clk1);
      while (bus1.req_ready !== 1'b1 && guard < 20) begin
        @(negedge clk1);
        guard++;
      end
      if (guard >= 20) begin
        check("w0_accept_timeout", 64'(guard), 64'd0);
        break;
      end
      @(posedge clk1); #1;
      a = cyc;
      if (i < 4) exp1_q.push_back({2'b00, 32'h0});
      else       exp1_q.push_back({2'b00, w0_data[i - 4]});
      acc1_q.push_back(a);
      if (i > 0) check("w0_spacing", 64'(a - prev_acc), 64'd3);
      prev_acc = a;
    end
    bus1.req_valid = 1'b0;
    repeat (4) @(posedge clk1);
    #1;
    check("w0_drained", 64'(exp1_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data-memory responder serving load/store requests from the 32-bit pipelined core over a valid/ready request and response handshake. It replaces the core's zero-latency internal array with a slave that has a configurable number of wait states. It also reports out-of-range accesses and, optionally, parity errors. Memory contents are not reset.

## Interface
- DEPTH, 1024, number of 32-bit words; must be a power of two, at least 2
- AW, 10, index width, equal to log2(DEPTH)
- WAIT, 2, wait states per access, range 0..15
- clk1  input  1  sole clock; all state changes on the rising edge
- rst  input  1  asynchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  responder can accept; high only in IDLE
- req_we  input  1  1 = store (SW), 0 = load (LW)
- req_addr  input  32  word index (same units as the core's ALU-computed address)
- req_wdata  input  32  store data
- rsp_valid  output  1  response present; held until accepted
- rsp_ready  input  1  core accepts the response
- rsp_rdata  output  32  load data; 0 for stores and for errors
- rsp_err  output  2  [0] address out of range, [1] parity error (always 0 when parity is compiled out)

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: capture we, addr and wdata; load cnt = WAIT; go to BUSY.
- BUSY:
  - req_ready = 0.
  - While cnt != 0: decrement cnt.
  - When cnt == 0, perform the access in the same edge and go to RESP:
    - Range check: addr >= DEPTH, i.e. any of bits [31:AW] set. On a range error no write occurs, rsp_rdata = 0 and rsp_err[0] = 1.
    - In-range store: mem[addr[AW-1:0]] <= wdata; rsp_rdata = 0.
    - In-range load: rsp_rdata = mem[addr[AW-1:0]].
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are stable.
  - On rsp_ready: go to IDLE, and drop rsp_valid, rsp_rdata and rsp_err to 0.
- Captured request fields are frozen from the accept edge onward. Changes on req_* inputs outside IDLE are ignored.
- Only one outstanding request. A response is never accepted in the same edge that a new request is accepted.
- Reset:
  - Asynchronous; forces IDLE, cnt = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 1 once reset is released.
  - Reset asserted in BUSY before the access edge aborts the request; a pending store is not written.
  - Reset in RESP discards the response; a store already written stays written.
  - Memory array contents are never cleared by reset.

## Timing
- Request accepted at edge N, i.e. req_valid is high while in IDLE.
- BUSY covers edges N+1 .. N+WAIT+1; the access happens at edge N+WAIT+1.
- rsp_valid is high from after edge N+WAIT+1 until the edge where rsp_ready is sampled high, inclusive.
- req_ready returns to 1 after the response-accept edge. The next request can be accepted one edge later.
- Minimum request-to-request spacing is WAIT+3 cycles, with rsp_ready tied high.
- WAIT = 0 gives a one-cycle BUSY; the response is visible after edge N+1.
- Outputs are registered or state-decoded; there is no combinational path from any input to any output.

## Configuration
- DMEM_PARITY_EN defined:
  - A parity bit array par[DEPTH] is instantiated.
  - Every in-range store writes par = ^wdata.
  - Every in-range load computes ^mem ^ par; a value of 1 sets rsp_err[1]. rsp_rdata still carries the stored word.
  - The parity array is not reset.
- DMEM_PARITY_EN undefined:
  - No parity storage.
  - rsp_err[1] is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, WAIT=2, store addr 5 data 0xDEADBEEF:
  - rsp_valid rises exactly 3 edges after accept.
  - rsp_err = 0, rsp_rdata = 0.
  - A subsequent load of addr 5 returns 0xDEADBEEF with rsp_err = 0.
- Load addr 1024 and store addr 0x8000_0003 (DEPTH = 1024):
  - Both give rsp_err = 2'b01, rsp_rdata = 0.
  - Word 3 is unchanged on a later load.
- Hold rsp_ready = 0 for 5 cycles:
  - rsp_valid, rsp_rdata and rsp_err stay stable; req_ready = 0 throughout.
  - req_valid pulses during this time are not accepted.
  - After rsp_ready = 1, req_ready rises on the next cycle.
- Store addr 7 data 0x1234_5678, then assert rst one cycle after accept (WAIT = 2):
  - Outputs reset immediately.
  - A later load of addr 7 returns the pre-store value.
  - Memory written before the reset is preserved.
- WAIT = 0, back-to-back loads with rsp_ready tied high:
  - The response follows accept by 1 edge.
  - Accepts occur every 3 cycles.
- DMEM_PARITY_EN only: store addr 9 data 0x0000_0001, flip par[9] via hierarchical deposit, then load addr 9:
  - rsp_rdata = 0x0000_0001, rsp_err = 2'b10.
